// File: rtl/divider_4bit_seq_pkg.sv
// divider_4bit_seq_pkg: shared state encoding, default width and iteration counter width for the divider
package divider_4bit_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DIV_WIDTH = 4;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);
endpackage

// File: rtl/divider_4bit_seq_subtractor.sv
// subtractor_4bit: WIDTH-bit ripple-borrow subtractor built from full-subtractor cells, borrow-in tied 0
module subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);
  logic [WIDTH:0] bw;
  assign bw[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fs
    assign diff_o[i] = a_i[i] ^ b_i[i] ^ bw[i];
    assign bw[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
  end
  assign borrow_o = bw[WIDTH];
endmodule

// File: rtl/divider_4bit_seq.sv
// divider_4bit_seq: sequential restoring divider with Start/Busy/Done handshake; DIV_ZERO_FAST_EN skips RUN for B==0
module divider_4bit_seq
  import divider_4bit_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, r_q, quot_q, rem_q;
  logic [WIDTH-2:0] quo_q;
  logic             dbz_q, busy_q, done_q;
  logic [WIDTH:0]   s_d;
  logic [WIDTH-1:0] diff, r_d, quo_d;
  logic             borrow, q_bit;
  assign s_d = {r_q, dvd_q[WIDTH-1]};
  subtractor_4bit #(.WIDTH(WIDTH)) u_sub (
    .a_i     (s_d[WIDTH-1:0]),
    .b_i     (dvs_q),
    .diff_o  (diff),
    .borrow_o(borrow)
  );
  // one restoring step: a quotient bit is 1 when the shifted-out bit is set or the trial subtraction did not borrow
  always_comb begin
    q_bit = s_d[WIDTH] | ~borrow;
    r_d   = q_bit ? diff : s_d[WIDTH-1:0];
    quo_d = {quo_q, q_bit};
  end
  // control FSM, shift registers and registered result/handshake outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          dvd_q <= A;
          dvs_q <= B;
          r_q   <= '0;
          quo_q <= '0;
          cnt_q <= '0;
`ifdef DIV_ZERO_FAST_EN
          if (B == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quot_q  <= '1;
            rem_q   <= A;
            dbz_q   <= 1'b1;
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
`else
          state_q <= RUN;
          busy_q  <= 1'b1;
`endif
        end
        RUN: begin
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          r_q   <= r_d;
          quo_q <= quo_d[WIDTH-2:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= quo_d;
            rem_q   <= r_d;
            dbz_q   <= (dvs_q == '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb_divider_4bit_seq: table, hand-written and randomized checks of divider_4bit_seq against an arithmetic model
module tb_divider_4bit_seq;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [3:0] Quotient, Remainder;
  logic       Busy, Done, DivByZero;
  int         tests = 0, fails = 0, dones = 0;

  divider_4bit_seq dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       z;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] mq(input logic [3:0] a, input logic [3:0] b);
    return (b == 0) ? 4'hF : 4'(a / b);
  endfunction

  function automatic logic [3:0] mr(input logic [3:0] a, input logic [3:0] b);
    return (b == 0) ? a : 4'(a % b);
  endfunction

  function automatic int exp_lat(input logic [3:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 0) ? 0 : 4;
`else
    return 4;
`endif
  endfunction

  // called #1 after an edge with the DUT in IDLE; returns #1 after the edge following Done
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                        input logic [3:0] er, input logic ez, input bit timing, input bit disturb);
    int lat = 0, busy = 0;
    A = a; B = b; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    while (!Done && lat < 20) begin
      busy += int'(Busy);
      if (disturb && lat == 1) begin A = 4'd3; B = 4'd3; Start = 1'b1; end
      if (disturb && lat == 2) begin A = 4'd0; B = 4'd0; Start = 1'b0; end
      @(posedge CLK); #1;
      lat++;
    end
    Start = 1'b0;
    if (!Done) begin
      fails++; tests++;
      $display("FAIL timeout a=%0d b=%0d: no Done within 20 cycles", a, b);
      return;
    end
    dones++;
    chk($sformatf("quot %0d/%0d", a, b), Quotient, eq);
    chk($sformatf("rem %0d/%0d", a, b), Remainder, er);
    chk($sformatf("dbz %0d/%0d", a, b), DivByZero, ez);
    if (timing) begin
      chk($sformatf("latency %0d/%0d", a, b), lat, exp_lat(b));
      chk($sformatf("busy cycles %0d/%0d", a, b), busy, exp_lat(b));
    end
    @(posedge CLK); #1;
    if (timing) chk("done one-cycle pulse", Done, 0);
  endtask

  initial begin
    vt[0] = '{4'd13, 4'd3, 4'd4,  4'd1, 1'b0};
    vt[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    vt[2] = '{4'd7,  4'd9, 4'd0,  4'd7, 1'b0};
    vt[3] = '{4'd9,  4'd0, 4'd15, 4'd9, 1'b1};
    repeat (2) @(posedge CLK);
    #1;
    chk("reset quot", Quotient, 0);
    chk("reset rem", Remainder, 0);
    chk("reset busy", Busy, 0);
    chk("reset done", Done, 0);
    chk("reset dbz", DivByZero, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++)
      do_div(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z, 1'b1, 1'b0);
    do_div(4'd10, 4'd2, 4'd5, 4'd0, 1'b0, 1'b1, 1'b1);
    do_div(4'd3, 4'd3, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("hold quot after done", Quotient, 1);
    A = 4'd14; B = 4'd4; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("async reset quot", Quotient, 0);
    chk("async reset rem", Remainder, 0);
    chk("async reset busy", Busy, 0);
    chk("async reset done", Done, 0);
    chk("async reset dbz", DivByZero, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    begin
      int seen = 0;
      repeat (8) begin
        @(posedge CLK); #1;
        seen += int'(Done) + int'(Busy);
      end
      chk("no done/busy after reset", seen, 0);
    end
    do_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(15));
      b = 4'($urandom_range(15));
      do_div(a, b, mq(a, b), mr(a, b), b == 0, 1'b1, 1'b0);
    end
    dones = 0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      a = 4'(i >> 4);
      b = 4'(i);
      do_div(a, b, mq(a, b), mr(a, b), b == 0, 1'b0, 1'b0);
    end
    chk("sweep done count", dones, 256);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
